// File: rtl/vector_dot_product_seq_pkg.sv
// ============================================================================
// Module  : vector_dot_product_seq_pkg
// Brief   : Shared FSM encodings and float32 constants for the dot-product core.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vector_dot_product_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

`default_nettype wire

// File: rtl/FloatingAddition.sv
// ============================================================================
// Module  : FloatingAddition
// Brief   : Combinational float32 add, round-to-nearest-even, denormals
//           flushed to zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module FloatingAddition
  import vector_dot_product_seq_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result
);

  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic        w_swap, w_sub, w_s_l, w_found, w_up;
  logic [7:0]  w_e_l, w_e_s, w_d;
  logic [22:0] w_f_l, w_f_s, w_frac;
  logic [49:0] w_ext;
  logic [26:0] w_lg, w_sm, w_diff, w_norm;
  logic [27:0] w_sum;
  logic [4:0]  w_lz;
  logic [24:0] w_rnd;
  logic [9:0]  w_e;

  always_comb begin
    w_a_zero = (i_a[30:23] == 8'h00);
    w_b_zero = (i_b[30:23] == 8'h00);
    w_a_inf  = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
    w_b_inf  = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);
    w_a_nan  = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
    w_b_nan  = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);

    w_swap = (i_b[30:0] > i_a[30:0]);
    w_sub  = i_a[31] ^ i_b[31];
    w_s_l  = w_swap ? i_b[31]    : i_a[31];
    w_e_l  = w_swap ? i_b[30:23] : i_a[30:23];
    w_f_l  = w_swap ? i_b[22:0]  : i_a[22:0];
    w_e_s  = w_swap ? i_a[30:23] : i_b[30:23];
    w_f_s  = w_swap ? i_a[22:0]  : i_b[22:0];
    w_d    = w_e_l - w_e_s;

    // Smaller operand aligned to 24 mantissa bits + guard + round + sticky.
    w_ext  = {1'b1, w_f_s, 26'd0} >> w_d;
    w_sm   = {w_ext[49:24], |w_ext[23:0]};
    w_lg   = {1'b1, w_f_l, 3'b000};
    w_sum  = {1'b0, w_lg} + {1'b0, w_sm};
    w_diff = w_lg - w_sm;

    w_lz    = 5'd0;
    w_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!w_found) begin
        if (w_diff[i]) w_found = 1'b1;
        else           w_lz    = w_lz + 5'd1;
      end
    end

    // Exponent carried with a +32 offset so cancellation cannot wrap below zero.
    if (w_sub) begin
      w_norm = w_diff << w_lz;
      w_e    = {2'b00, w_e_l} + 10'd32 - {5'd0, w_lz};
    end else if (w_sum[27]) begin
      w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_e    = {2'b00, w_e_l} + 10'd33;
    end else begin
      w_norm = w_sum[26:0];
      w_e    = {2'b00, w_e_l} + 10'd32;
    end

    w_up   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rnd  = {1'b0, w_norm[26:3]} + {24'd0, w_up};
    w_e    = w_e + {9'd0, w_rnd[24]};
    w_frac = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_sub)) begin
      o_result = FP_QNAN;
    end else if (w_a_inf) begin
      o_result = i_a;
    end else if (w_b_inf) begin
      o_result = i_b;
    end else if (w_a_zero && w_b_zero) begin
      o_result = {i_a[31] & i_b[31], 31'd0};
    end else if (w_a_zero) begin
      o_result = i_b;
    end else if (w_b_zero) begin
      o_result = i_a;
    end else if (w_sub && (w_diff == 27'd0)) begin
      o_result = FP_ZERO;
    end else if (w_e >= 10'd287) begin
      o_result = {w_s_l, 8'hFF, 23'd0};
    end else if (w_e <= 10'd32) begin
      o_result = {w_s_l, 31'd0};
    end else begin
      o_result = {w_s_l, 8'(w_e - 10'd32), w_frac};
    end
  end

endmodule

`default_nettype wire

// File: rtl/FloatingMultiplication.sv
// ============================================================================
// Module  : FloatingMultiplication
// Brief   : Combinational float32 multiply, round-to-nearest-even, denormals
//           flushed to zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module FloatingMultiplication
  import vector_dot_product_seq_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result
);

  logic        w_sign;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [47:0] w_prod;
  logic [22:0] w_frac;
  logic        w_guard, w_sticky, w_up;
  logic [23:0] w_rnd;
  logic [9:0]  w_exp_b;

  always_comb begin
    w_sign   = i_a[31] ^ i_b[31];
    w_a_zero = (i_a[30:23] == 8'h00);
    w_b_zero = (i_b[30:23] == 8'h00);
    w_a_inf  = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
    w_b_inf  = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);
    w_a_nan  = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
    w_b_nan  = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);

    w_prod = 48'({1'b1, i_a[22:0]}) * 48'({1'b1, i_b[22:0]});
    if (w_prod[47]) begin
      w_frac   = w_prod[46:24];
      w_guard  = w_prod[23];
      w_sticky = |w_prod[22:0];
    end else begin
      w_frac   = w_prod[45:23];
      w_guard  = w_prod[22];
      w_sticky = |w_prod[21:0];
    end
    w_up  = w_guard & (w_sticky | w_frac[0]);
    w_rnd = {1'b0, w_frac} + {23'd0, w_up};

    // Sum of biased exponents; the true biased result is w_exp_b - 127.
    w_exp_b = {2'b00, i_a[30:23]} + {2'b00, i_b[30:23]}
            + {9'd0, w_prod[47]} + {9'd0, w_rnd[23]};

    if (w_a_nan || w_b_nan) begin
      o_result = FP_QNAN;
    end else if (w_a_inf || w_b_inf) begin
      o_result = (w_a_zero || w_b_zero) ? FP_QNAN : {w_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      o_result = {w_sign, 31'd0};
    end else if (w_exp_b >= 10'd382) begin
      o_result = {w_sign, 8'hFF, 23'd0};
    end else if (w_exp_b <= 10'd127) begin
      o_result = {w_sign, 31'd0};
    end else begin
      o_result = {w_sign, 8'(w_exp_b - 10'd127), w_rnd[22:0]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/vector_lane_sum.sv
// ============================================================================
// Module  : vector_lane_sum
// Brief   : LANES parallel float32 products reduced by a strict left-to-right
//           addition chain ((p0+p1)+p2)+...  Purely combinational.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vector_lane_sum
  import vector_dot_product_seq_pkg::*;
#(
  parameter int LANES = 2
)
(
  input  logic [32*LANES-1:0] i_a,
  input  logic [32*LANES-1:0] i_b,
  output logic [31:0]         o_sum
);

  logic [32*LANES-1:0] w_prod;
  logic [32*LANES-1:0] w_chain;

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      FloatingMultiplication u_mul (
        .i_a      (i_a[32*g +: 32]),
        .i_b      (i_b[32*g +: 32]),
        .o_result (w_prod[32*g +: 32])
      );
      if (g == 0) begin : g_first
        assign w_chain[31:0] = w_prod[31:0];
      end else begin : g_add
        FloatingAddition u_add (
          .i_a      (w_chain[32*(g-1) +: 32]),
          .i_b      (w_prod[32*g +: 32]),
          .o_result (w_chain[32*g +: 32])
        );
      end
    end
  endgenerate

  assign o_sum = w_chain[32*LANES-1 -: 32];

endmodule

`default_nettype wire

// File: rtl/vector_dot_product_seq.sv
// ============================================================================
// Module  : vector_dot_product_seq
// Brief   : Sequential float32 dot product, LANES elements per cycle.
//           Optional ReLU output: define VECTOR_DOT_PRODUCT_SEQ_RELU_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vector_dot_product_seq
  import vector_dot_product_seq_pkg::*;
#(
  parameter int VLEN  = 4,
  parameter int LANES = 2
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [32*VLEN-1:0] A,
  input  logic [32*VLEN-1:0] B,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result
);

  localparam int NCHUNK = VLEN / LANES;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  generate
    if ((LANES < 1) || (VLEN % LANES != 0)) begin : g_bad_cfg
      $error("VLEN must be a positive multiple of LANES");
    end
  endgenerate

  logic [1:0]          r_state;
  logic [KW-1:0]       r_k;
  logic [32*VLEN-1:0]  r_a;
  logic [32*VLEN-1:0]  r_b;
  logic [31:0]         r_acc;

  logic [32*LANES-1:0] w_a_chunk;
  logic [32*LANES-1:0] w_b_chunk;
  logic [31:0]         w_chunk_sum;
  logic [31:0]         w_acc_sum;

  assign w_a_chunk = r_a[int'(r_k)*32*LANES +: 32*LANES];
  assign w_b_chunk = r_b[int'(r_k)*32*LANES +: 32*LANES];

  vector_lane_sum #(.LANES(LANES)) u_lane_sum (
    .i_a   (w_a_chunk),
    .i_b   (w_b_chunk),
    .o_sum (w_chunk_sum)
  );

  // Accumulator is operand A so the running sum stays on the left of the chain.
  FloatingAddition u_acc_add (
    .i_a      (r_acc),
    .i_b      (w_chunk_sum),
    .o_result (w_acc_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_acc   <= FP_ZERO;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_k     <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_acc <= (r_k == '0) ? w_chunk_sum : w_acc_sum;
          if (r_k == K_LAST) begin
            r_k     <= '0;
            r_state <= ST_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign out_valid = (r_state == ST_DONE);

`ifdef VECTOR_DOT_PRODUCT_SEQ_RELU_EN
  assign result = r_acc[31] ? FP_ZERO : r_acc;
`else
  assign result = r_acc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vector_dot_product_seq.sv
// ============================================================================
// Module  : tb_vector_dot_product_seq
// Brief   : Scoreboard bench for vector_dot_product_seq at LANES = 1, 2, 4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vector_dot_product_seq;

  localparam int VLEN = 4;

  typedef struct {
    logic [31:0] res;
    int          start;
    int          lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             out_ready;
  logic [32*VLEN-1:0] A;
  logic [32*VLEN-1:0] B;
  logic [2:0]       w_busy;
  logic [2:0]       w_ov;
  logic [31:0]      w_res [3];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  exp_t sb_q0[$];
  exp_t sb_q1[$];
  exp_t sb_q2[$];

  // Instance 0: LANES=1, instance 1: LANES=2, instance 2: LANES=4.
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      vector_dot_product_seq #(
        .VLEN  (VLEN),
        .LANES ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (w_busy[g]),
        .out_valid (w_ov[g]),
        .out_ready (out_ready),
        .result    (w_res[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  function automatic int lat_of(input int idx);
    case (idx)
      0:       return 5;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] to_f32(input int v);
    logic [31:0] m;
    int          p;
    if (v == 0) return 32'h0;
    m = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return {(v < 0), 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  function automatic logic [31:0] act_fn(input logic [31:0] v);
`ifdef VECTOR_DOT_PRODUCT_SEQ_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [32*VLEN-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {to_f32(e3), to_f32(e2), to_f32(e1), to_f32(e0)};
  endfunction

  task automatic sb_push(input int idx, input exp_t e);
    case (idx)
      0:       sb_q0.push_back(e);
      1:       sb_q1.push_back(e);
      default: sb_q2.push_back(e);
    endcase
  endtask

  function automatic int sb_size(input int idx);
    case (idx)
      0:       return sb_q0.size();
      1:       return sb_q1.size();
      default: return sb_q2.size();
    endcase
  endfunction

  task automatic sb_pop(input int idx, output exp_t e);
    case (idx)
      0:       e = sb_q0.pop_front();
      1:       e = sb_q1.pop_front();
      default: e = sb_q2.pop_front();
    endcase
  endtask

  task automatic monitor(input int idx);
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (w_ov[idx] && !prev) begin
        check($sformatf("busy_with_valid_l%0d", idx), 32'(w_busy[idx]), 32'd1);
        if (sb_size(idx) == 0) begin
          check($sformatf("unexpected_result_l%0d", idx), 32'(sb_size(idx)), 32'd1);
        end else begin
          sb_pop(idx, e);
          check($sformatf("result_l%0d", idx), w_res[idx], e.res);
          check($sformatf("latency_l%0d", idx), 32'(cyc - e.start + 1), 32'(e.lat));
        end
      end
      prev = w_ov[idx];
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  // Pulse start for one cycle and record the expected result for the chosen instances.
  task automatic issue(input logic [32*VLEN-1:0] a, input logic [32*VLEN-1:0] b,
                       input logic [31:0] exp, input logic [2:0] mask);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        e.res   = exp;
        e.start = cyc;
        e.lat   = lat_of(i);
        sb_push(i, e);
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((w_busy != 3'b000) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 50), 32'd1);
  endtask

  logic [32*VLEN-1:0] v_a10, v_b1, v_alt;

  initial begin
    int ea [4];
    int eb [4];
    int dot;
    int n;

    v_a10 = pack4(1, 2, 3, 4);
    v_b1  = pack4(1, 1, 1, 1);
    v_alt = pack4(7, 7, 7, 7);

    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_busy_l%0d", i), 32'(w_busy[i]), 32'd0);
      check($sformatf("reset_valid_l%0d", i), 32'(w_ov[i]), 32'd0);
      check($sformatf("reset_result_l%0d", i), w_res[i], 32'h0);
    end
    rst = 1'b0;

    // Basic transaction: {1,2,3,4} . {1,1,1,1} = 10.0
    issue(v_a10, v_b1, 32'h4120_0000, 3'b111);
    wait_idle("idle_after_basic");

    // Back-pressure: hold, then handshake together with an ignored start.
    @(negedge clk);
    out_ready = 1'b0;
    issue(v_a10, v_b1, 32'h4120_0000, 3'b111);
    n = 0;
    while ((w_ov != 3'b111) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    check("hold_wait_all_valid", 32'(n < 40), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("hold_valid_l%0d_c%0d", i, c), 32'(w_ov[i]), 32'd1);
        check($sformatf("hold_result_l%0d_c%0d", i, c), w_res[i], 32'h4120_0000);
      end
    end
    out_ready = 1'b1;
    start = 1'b1;
    A = v_alt;
    B = v_alt;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("release_valid_l%0d", i), 32'(w_ov[i]), 32'd0);
      check($sformatf("release_busy_l%0d", i), 32'(w_busy[i]), 32'd0);
    end

    // start re-asserted during RUN with different operands is ignored.
    issue(v_a10, v_b1, 32'h4120_0000, 3'b111);
    @(negedge clk);
    A = v_alt;
    B = v_alt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("idle_after_ignore");

    // Reset in the second RUN cycle of the LANES=2 instance; LANES=4 has already finished.
    issue(v_a10, v_b1, 32'h4120_0000, 3'b100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midrun_rst_busy_l%0d", i), 32'(w_busy[i]), 32'd0);
      check($sformatf("midrun_rst_valid_l%0d", i), 32'(w_ov[i]), 32'd0);
      check($sformatf("midrun_rst_result_l%0d", i), w_res[i], 32'h0);
    end
    issue(v_a10, v_b1, 32'h4120_0000, 3'b111);
    wait_idle("idle_after_reset_restart");

    // Negative sum: -10.0, or 0 with the output activation.
    issue(pack4(-1, -2, -3, -4), v_b1, act_fn(32'hC120_0000), 3'b111);
    wait_idle("idle_after_negative");

    // A = B = {2,2,2,2}: 16.0
    issue(pack4(2, 2, 2, 2), pack4(2, 2, 2, 2), 32'h4180_0000, 3'b111);
    wait_idle("idle_after_sixteen");

    // Small signed integers: every partial sum is exact, so the integer model is exact.
    for (int t = 0; t < 6; t++) begin
      do begin
        dot = 0;
        for (int i = 0; i < 4; i++) begin
          ea[i] = int'($urandom_range(1, 9)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
          eb[i] = int'($urandom_range(1, 9)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
          dot += ea[i] * eb[i];
        end
      end while (dot == 0);
      issue(pack4(ea[0], ea[1], ea[2], ea[3]), pack4(eb[0], eb[1], eb[2], eb[3]),
            act_fn(to_f32(dot)), 3'b111);
      wait_idle($sformatf("idle_after_random_%0d", t));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q0.size() + sb_q1.size() + sb_q2.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
